// File: rtl/rv32i_mem_responder.sv
// Word-addressed RV32I data memory responder with byte-lane writes, a fixed
// number of wait states and a single-cycle registered completion pulse.
module rv32i_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    input  logic        mem_write,
    input  logic        mem_read,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_err,
    output logic        mem_busy
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [29:0]    waddr_q, waddr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [3:0]     wstrb_q, wstrb_d;
    logic           is_write_q, is_write_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           ready_q, ready_d;
    logic           err_q, err_d;
    logic           busy_q, busy_d;

    logic [31:0]    mem_q [DEPTH_WORDS];

    logic [29:0]    req_waddr_c;
    logic [31:0]    req_wdata_c;
    logic [3:0]     req_wstrb_c;
    logic           req_write_c;
    logic [AW-1:0]  req_idx_c;
    logic           req_oor_c;
    logic           enter_resp_c;
    logic           commit_c;
    logic [31:0]    old_word_c;
    logic [31:0]    merged_c;

    // Byte offset within a word never matters.
    logic           addr_lsb_unused;
    assign addr_lsb_unused = ^mem_addr[1:0];

    // Next-state, request capture and response generation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        is_write_d   = is_write_q;
        rdata_d      = rdata_q;
        ready_d      = 1'b0;
        err_d        = 1'b0;
        busy_d       = 1'b0;
        req_waddr_c  = waddr_q;
        req_wdata_c  = wdata_q;
        req_wstrb_c  = wstrb_q;
        req_write_c  = is_write_q;
        enter_resp_c = 1'b0;
        commit_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    // Live inputs are used directly so a zero-wait response can commit now.
                    req_waddr_c = mem_addr[31:2];
                    req_wdata_c = mem_wdata;
                    req_wstrb_c = mem_wstrb;
                    req_write_c = mem_write;
                    waddr_d     = mem_addr[31:2];
                    wdata_d     = mem_wdata;
                    wstrb_d     = mem_wstrb;
                    is_write_d  = mem_write;
                    if (WAIT_CYCLES == 0) begin
                        enter_resp_c = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CW'(WAIT_CYCLES - 1);
                        busy_d  = 1'b1;
                    end
                end
            end
            WAIT: begin
                busy_d = 1'b1;
                if (cnt_q == '0) begin
                    enter_resp_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_idx_c  = req_waddr_c[AW-1:0];
        req_oor_c  = |req_waddr_c[29:AW];
        old_word_c = mem_q[req_idx_c];
        merged_c   = old_word_c;
        for (int b = 0; b < 4; b++) begin
            if (req_wstrb_c[b]) begin
                merged_c[8*b +: 8] = req_wdata_c[8*b +: 8];
            end
        end

        if (enter_resp_c) begin
            state_d  = RESP;
            busy_d   = 1'b1;
            ready_d  = 1'b1;
            err_d    = req_oor_c;
            rdata_d  = (req_write_c || req_oor_c) ? 32'h0 : old_word_c;
            commit_c = req_write_c && !req_oor_c;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            is_write_q <= 1'b0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            is_write_q <= is_write_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    // Array is never reset; a write aborted by reset never reaches it.
    always_ff @(posedge clk) begin
        if (rstn && commit_c) begin
            mem_q[req_idx_c] <= merged_c;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign mem_err   = err_q;
    assign mem_busy  = busy_q;

endmodule
